// File: rtl/ir_frame_tx_if.sv
// ir_frame_tx_if: request/payload handshake and LED drive lines of the IR frame transmitter.
interface ir_frame_tx_if #(parameter int F1_BITS = 35, parameter int F2_BITS = 32);
  localparam int F2W = F2_BITS > 0 ? F2_BITS : 1;
  logic start, abort;
  logic [F1_BITS-1:0] data1;
  logic [F2W-1:0] data2;
  logic [3:0] reps;
  logic ready, busy, done, ir_env, ir_out, led_out;
  modport master(output start, abort, data1, data2, reps, input ready, busy, done, ir_env, ir_out, led_out);
  modport slave(input start, abort, data1, data2, reps, output ready, busy, done, ir_env, ir_out, led_out);
endinterface

// File: rtl/ir_frame_tx.sv
// ir_frame_tx: two-segment IR remote frame serialiser with repeat count and optional carrier.
module ir_frame_tx #(
  parameter int UNIT_CYC = 22400,
  parameter int CARR_DIV = 1052,
  parameter int MOD_EN = 1,
  parameter int F1_BITS = 35,
  parameter int F2_BITS = 32,
  parameter int LEAD_MARK = 16,
  parameter int LEAD_SPACE = 8,
  parameter int ZERO_SPACE = 1,
  parameter int ONE_SPACE = 3,
  parameter int GAP_SPACE = 36,
  parameter int REP_SPACE = 72
) (
  input logic clk,
  input logic rst,
  ir_frame_tx_if.slave bus
);
  function automatic int mx(input int a, input int b);
    return a > b ? a : b;
  endfunction
  localparam int F2W = F2_BITS > 0 ? F2_BITS : 1;
  localparam int SW = mx(F1_BITS, F2W);
  localparam int UW = $clog2(UNIT_CYC);
  localparam int PW = $clog2(CARR_DIV);
  localparam int DMAX = mx(mx(mx(LEAD_MARK, LEAD_SPACE), mx(ZERO_SPACE, ONE_SPACE)), mx(GAP_SPACE, REP_SPACE));
  localparam int DW = mx($clog2(DMAX), 7);
  typedef enum logic [3:0] {IDLE, LEAD_M, LEAD_S, B1_M, B1_S, GAP_M, GAP_S, B2_M, B2_S, STOP_M, REP_S} state_t;
  state_t state, ns, nst;
  logic busy, done, env, out;
  logic [UW-1:0] ucnt;
  logic [DW-1:0] dcnt;
  logic [6:0] bidx, nb;
  logic [3:0] rcnt;
  logic [PW-1:0] ph, np;
  logic [F1_BITS-1:0] d1;
  logic [F2W-1:0] d2;
  logic [SW-1:0] sh;
  logic acc, last_u, adv, fin, nenv;
  int nd;
  always_comb begin
    ns = state;
    nd = 1;
    nb = bidx;
    case (state)
      LEAD_M: begin ns = LEAD_S; nd = LEAD_SPACE; end
      LEAD_S: begin ns = B1_M; nb = '0; end
      B1_M, B2_M: begin ns = state == B1_M ? B1_S : B2_S; nd = sh[0] ? ONE_SPACE : ZERO_SPACE; end
      B1_S: begin ns = bidx == 7'(F1_BITS-1) ? (F2_BITS == 0 ? STOP_M : GAP_M) : B1_M; nb = bidx + 1'b1; end
      GAP_M: begin ns = GAP_S; nd = GAP_SPACE; end
      GAP_S: begin ns = B2_M; nb = '0; end
      B2_S: begin ns = bidx == 7'(F2W-1) ? STOP_M : B2_M; nb = bidx + 1'b1; end
      STOP_M: begin ns = rcnt == 4'd0 ? IDLE : REP_S; nd = REP_SPACE; end
      REP_S: begin ns = LEAD_M; nd = LEAD_MARK; end
      default: ns = IDLE;
    endcase
    acc = bus.start && !busy;
    last_u = ucnt == UW'(UNIT_CYC-1);
    adv = busy && last_u && dcnt == '0;
    fin = adv && ns == IDLE;
    nst = acc ? LEAD_M : adv ? ns : state;
    nenv = nst inside {LEAD_M, B1_M, GAP_M, B2_M, STOP_M};
    // carrier phase restarts on every state entry so each mark opens with a full high half-period
    np = (acc || adv || ph == PW'(CARR_DIV-1)) ? '0 : ph + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst || bus.abort) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      env <= 1'b0;
      out <= 1'b0;
      ucnt <= '0;
      dcnt <= '0;
      bidx <= '0;
      rcnt <= '0;
      ph <= '0;
      d1 <= '0;
      d2 <= '0;
      sh <= '0;
    end else begin
      state <= nst;
      env <= nenv;
      out <= nenv && (MOD_EN == 0 || np < PW'(CARR_DIV/2));
      ph <= np;
      done <= fin;
      busy <= acc || (busy && !fin);
      if (acc) begin
        d1 <= bus.data1;
        d2 <= bus.data2;
        rcnt <= bus.reps;
        bidx <= '0;
        ucnt <= '0;
        dcnt <= DW'(LEAD_MARK-1);
      end else if (adv) begin
        ucnt <= '0;
        dcnt <= DW'(nd-1);
        bidx <= nb;
        if (ns == REP_S) rcnt <= rcnt - 1'b1;
        if (state == LEAD_S) sh <= SW'(d1);
        else if (state == GAP_S) sh <= SW'(d2);
        else if (state == B1_S || state == B2_S) sh <= sh >> 1;
      end else if (busy) begin
        ucnt <= last_u ? '0 : ucnt + 1'b1;
        dcnt <= last_u ? dcnt - 1'b1 : dcnt;
      end
    end
  end
  assign bus.busy = busy;
  assign bus.ready = ~busy;
  assign bus.led_out = busy;
  assign bus.done = done;
  assign bus.ir_env = env;
  assign bus.ir_out = out;
endmodule

// File: tb/tb_ir_frame_tx.sv
// tb_ir_frame_tx: directed checks of frame timing, carrier, repeats, abort and reset.
module tb_ir_frame_tx;
  logic clk = 0, rst = 1, start = 0, abort = 0, sel = 0;
  logic [3:0] data1 = 0, reps = 0;
  logic [2:0] data2 = 0;
  int nchk = 0, nfail = 0;
  int env_err, out_err, lead_err, busy_err, rdy_err, busy_cnt, done_cnt, done_at;
  bit qb[$], qe[$], qo[$];
  always #5 clk = ~clk;
  ir_frame_tx_if #(.F1_BITS(4), .F2_BITS(3)) ia();
  ir_frame_tx_if #(.F1_BITS(4), .F2_BITS(0)) ib();
  assign ia.start = start & ~sel;
  assign ia.abort = abort & ~sel;
  assign ia.data1 = data1;
  assign ia.data2 = data2;
  assign ia.reps = reps;
  assign ib.start = start & sel;
  assign ib.abort = abort & sel;
  assign ib.data1 = data1;
  assign ib.data2 = 1'b0;
  assign ib.reps = reps;
  ir_frame_tx #(.UNIT_CYC(8), .CARR_DIV(4), .MOD_EN(1), .F1_BITS(4), .F2_BITS(3)) dut_a (.clk(clk), .rst(rst), .bus(ia));
  ir_frame_tx #(.UNIT_CYC(8), .CARR_DIV(4), .MOD_EN(0), .F1_BITS(4), .F2_BITS(0)) dut_b (.clk(clk), .rst(rst), .bus(ib));
  task automatic chk(input string tag, input int obs, input int exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic add(input int u, input bit m, input bit mod);
    for (int k = 0; k < u * 8; k++) begin
      qb.push_back(1'b1);
      qe.push_back(m);
      qo.push_back(m && (!mod || k % 4 < 2));
    end
  endtask
  task automatic qclear();
    qb.delete();
    qe.delete();
    qo.delete();
  endtask
  task automatic frame_a();
    int u [19] = '{16, 8, 1, 1, 1, 3, 1, 1, 1, 3, 1, 36, 1, 3, 1, 1, 1, 1, 1};
    for (int j = 0; j < 19; j++) add(u[j], j % 2 == 0, 1'b1);
  endtask
  task automatic frame_b();
    int u [11] = '{16, 8, 1, 3, 1, 3, 1, 3, 1, 3, 1};
    for (int j = 0; j < 11; j++) add(u[j], j % 2 == 0, 1'b0);
  endtask
  // kind: 0 plain, 1 start pulse with new data at poke, 2 abort at poke, 3 rst at poke, 4 start held
  task automatic capture(input int n, input bit s, input int poke, input int kind);
    logic e, o, b, r, l, d;
    bit xb, xe, xo;
    int cut;
    cut = (kind == 2 || kind == 3) ? poke : n;
    env_err = 0; out_err = 0; lead_err = 0; busy_err = 0; rdy_err = 0;
    busy_cnt = 0; done_cnt = 0; done_at = 0;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk); #1;
      if (i == 1 && kind != 4) begin
        start = 0; data1 = ~data1; data2 = ~data2; reps = ~reps;
      end
      e = s ? ib.ir_env : ia.ir_env;
      o = s ? ib.ir_out : ia.ir_out;
      b = s ? ib.busy : ia.busy;
      r = s ? ib.ready : ia.ready;
      l = s ? ib.led_out : ia.led_out;
      d = s ? ib.done : ia.done;
      xb = 0; xe = 0; xo = 0;
      if (i <= cut && i <= qb.size()) begin
        xb = qb[i-1]; xe = qe[i-1]; xo = qo[i-1];
      end
      if (b !== xb) busy_err++;
      if (e !== xe) env_err++;
      if (o !== xo) begin out_err++; if (i <= 128) lead_err++; end
      if (r !== !xb || l !== xb) rdy_err++;
      if (b === 1'b1) busy_cnt++;
      if (d === 1'b1) begin done_cnt++; if (done_at == 0) done_at = i; end
      if (i == poke) begin
        if (kind == 1) begin start = 1; data1 = 4'b0101; data2 = 3'b110; reps = 3; end
        if (kind == 2) abort = 1;
        if (kind == 3) rst = 1;
      end
      if (i == poke + 1) begin start = (kind == 4); abort = 0; rst = 0; end
    end
    start = 0;
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("rst ready", ia.ready, 1);
    chk("rst busy", ia.busy, 0);
    chk("rst env", ia.ir_env, 0);
    chk("rst out", ia.ir_out, 0);
    chk("rst done", ia.done, 0);
    chk("rst led", ia.led_out, 0);
    chk("rst ready b", ib.ready, 1);
    qclear(); frame_a();
    data1 = 4'b1010; data2 = 3'b001; reps = 0; start = 1;
    capture(700, 0, 0, 0);
    chk("t1 busy_cnt", busy_cnt, 656);
    chk("t1 done_cnt", done_cnt, 1);
    chk("t1 done_at", done_at, 657);
    chk("t1 env_err", env_err, 0);
    chk("t1 busy_err", busy_err, 0);
    chk("t1 rdy_led_err", rdy_err, 0);
    chk("t2 lead_out_err", lead_err, 0);
    chk("t2 out_err", out_err, 0);
    qclear(); frame_a(); add(72, 0, 1); frame_a(); add(72, 0, 1); frame_a();
    data1 = 4'b1010; data2 = 3'b001; reps = 2; start = 1;
    capture(3130, 0, 0, 0);
    chk("t3 busy_cnt", busy_cnt, 3120);
    chk("t3 done_cnt", done_cnt, 1);
    chk("t3 done_at", done_at, 3121);
    chk("t3 env_err", env_err, 0);
    chk("t3 out_err", out_err, 0);
    qclear(); frame_a();
    data1 = 4'b1010; data2 = 3'b001; reps = 0; start = 1;
    capture(700, 0, 100, 1);
    chk("t4 busy_cnt", busy_cnt, 656);
    chk("t4 done_at", done_at, 657);
    chk("t4 env_err", env_err, 0);
    chk("t4 out_err", out_err, 0);
    qclear(); frame_a(); qb.push_back(0); qe.push_back(0); qo.push_back(0); frame_a();
    data1 = 4'b1010; data2 = 3'b001; reps = 0; start = 1;
    capture(700, 0, 0, 4);
    chk("t4h busy_cnt", busy_cnt, 699);
    chk("t4h done_cnt", done_cnt, 1);
    chk("t4h env_err", env_err, 0);
    chk("t4h out_err", out_err, 0);
    abort = 1;
    @(posedge clk); #1 abort = 0;
    chk("t4h abort busy", ia.busy, 0);
    qclear(); frame_a();
    data1 = 4'b1010; data2 = 3'b001; reps = 0; start = 1;
    capture(320, 0, 300, 2);
    chk("t5a busy_cnt", busy_cnt, 300);
    chk("t5a done_cnt", done_cnt, 0);
    chk("t5a env_err", env_err, 0);
    chk("t5a out_err", out_err, 0);
    data1 = 4'b1010; data2 = 3'b001; reps = 0; start = 1;
    capture(320, 0, 300, 3);
    chk("t5r busy_cnt", busy_cnt, 300);
    chk("t5r done_cnt", done_cnt, 0);
    chk("t5r env_err", env_err, 0);
    chk("t5r out_err", out_err, 0);
    start = 1; abort = 1;
    @(posedge clk); #1;
    start = 0; abort = 0;
    chk("abort over start busy", ia.busy, 0);
    chk("abort over start env", ia.ir_env, 0);
    sel = 1;
    qclear(); frame_b();
    data1 = 4'b1111; reps = 0; start = 1;
    capture(340, 1, 0, 0);
    chk("t6 busy_cnt", busy_cnt, 328);
    chk("t6 done_at", done_at, 329);
    chk("t6 env_err", env_err, 0);
    chk("t6 out_err", out_err, 0);
    chk("t6 rdy_led_err", rdy_err, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/ir_frame_tx.md
Name: ir_frame_tx

Overview:
- Parametrised infrared remote-control frame transmitter for the air-conditioner remote; successor to the fixed 35+32-bit Gree-style sender.
- Serialises a two-segment frame (leader, segment 1, connect gap, segment 2, stop mark) with configurable segment lengths, unit timing, carrier modulation and repeat count.
- Fed by the key/command logic; drives the IR LED and the status LED.

Parameters:
- UNIT_CYC, 22400: clk cycles per timing unit (560 us at 40 MHz); must be ≥2.
- CARR_DIV, 1052: clk cycles per carrier period (~38 kHz); even, ≥2.
- MOD_EN, 1: 1 = marks carry the carrier; 0 = ir_out equals the envelope.
- F1_BITS, 35: segment-1 bit count, 1..64.
- F2_BITS, 32: segment-2 bit count, 0..64; 0 omits the connect gap and segment 2.
- LEAD_MARK, 16 / LEAD_SPACE, 8: leader durations in units.
- ZERO_SPACE, 1 / ONE_SPACE, 3: space after each bit mark, in units; every bit mark is 1 unit.
- GAP_SPACE, 36: connect-gap space after the 1-unit gap mark, in units.
- REP_SPACE, 72: space between repeated frames, in units.

Ports:
- clk, in, 1: system clock, 40 MHz.
- rst, in, 1: synchronous active-high reset.
- start, in, 1: transmit request, accepted when ready=1.
- abort, in, 1: synchronous cancel.
- data1, in, F1_BITS: segment-1 payload, sent LSB first.
- data2, in, max(F2_BITS,1): segment-2 payload, sent LSB first; ignored if F2_BITS=0.
- reps, in, 4: additional frame repetitions (total frames = reps+1).
- ready, out, 1: idle; equals ~busy.
- busy, out, 1: transmission in progress.
- done, out, 1: one-cycle completion pulse.
- ir_env, out, 1: mark envelope (1 = mark).
- ir_out, out, 1: IR LED drive.
- led_out, out, 1: status LED; equals busy.

Behaviour:
- Reset: all outputs 0 except ready=1; FSM in IDLE; counters cleared. rst mid-frame behaves the same, with no done pulse.
- Accept: start=1 and ready=1 at edge N.
  - data1, data2 and reps are latched at edge N.
  - From cycle N+1: busy=1 and ir_env=1 (leader mark). There is no extra latency.
  - start while busy is ignored; inputs may change freely after acceptance.
- FSM states: IDLE → LEAD_M → LEAD_S → B1_M/B1_S (×F1_BITS) → GAP_M → GAP_S → B2_M/B2_S (×F2_BITS) → STOP_M → (REP_S → LEAD_M if repeats remain) → IDLE.
  - GAP and B2 states are skipped when F2_BITS=0.
- Segment timing: each state lasts exactly duration×UNIT_CYC cycles.
  - Mark states (ir_env=1): LEAD_M, B*_M, GAP_M, STOP_M.
  - All other states are spaces (ir_env=0).
  - B*_S duration is ONE_SPACE if the current bit is 1, else ZERO_SPACE.
  - Bit index runs 0..N-1 (LSB first). There are no idle cycles between states.
- Repeats:
  - The repeat counter loads reps at accept and decrements on each STOP_M→REP_S.
  - When the counter is 0, STOP_M→IDLE.
  - Repeated frames resend the same latched data.
- Completion:
  - busy falls in the cycle after the final STOP_M cycle.
  - done=1 for exactly that one cycle. ready rises in the same cycle, so start may be accepted on that edge.
- Carrier (MOD_EN=1):
  - The carrier phase counter resets to 0 at the first cycle of every mark state.
  - ir_out = 1 when ir_env=1 and phase < CARR_DIV/2; otherwise 0.
  - The phase counter wraps at CARR_DIV−1.
  - ir_out = 0 during spaces and idle.
- abort=1 in any state:
  - Next cycle: IDLE, busy=0, ir_env=0, ir_out=0, no done.
  - abort has priority over start in the same cycle.
- Counter widths: unit counter ≥ clog2(UNIT_CYC); duration counter ≥ 7 bits; bit index ≥ 7 bits; no overflow for legal parameters.

Test Plan:
All tests use UNIT_CYC=8, CARR_DIV=4, F1_BITS=4, F2_BITS=3 unless stated otherwise.
1. Reset, then start with data1=4'b1010, data2=3'b001, reps=0 → busy high for exactly 82×8=656 cycles.
   - ir_env mark/space unit pattern: 16/8, 1/1,1/3,1/1,1/3, 1/36, 1/3,1/1,1/1, 1.
   - done is a single pulse in cycle 657.
2. Same config, checking ir_out during the leader mark → pattern 1,1,0,0 repeating for 128 cycles.
   - Phase restarts at each mark; ir_out=0 in all spaces.
3. Same config, reps=2 → three identical frames separated by 72×8-cycle spaces.
   - busy = 3×656 + 2×576 = 3120 cycles; exactly one done pulse.
4. Start pulsed again at cycle 100 while busy with different data → ignored; output is identical to test 1.
   - Start held high across done → new frame begins the cycle after done.
5. abort at cycle 300 → busy, ir_env and ir_out are 0 from cycle 301; no done.
   - Repeat the same check with rst=1 at cycle 300.
6. F2_BITS=0, MOD_EN=0, data1=4'b1111 → ir_out equals ir_env throughout.
   - Frame = 24+16+1 = 41 units = 328 cycles; no gap segment.
